logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's single-function gate modules. One block provides AND/OR/NAND/NOR/XOR/XNOR/NOT plus an XOR-accumulate mode, at any width.
- Operands enter through a valid/ready handshake. Results, with zero/ones/parity flags, leave through a registered valid/ready output backed by a skid buffer.
- Sits between operand producers and downstream datapath consumers that may stall.

Parameters:
- WIDTH, 4, operand and result width in bits (≥1).
- OP_W, 3, opcode width (fixed at 3; exposed for the package).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_op  input  OP_W  operation select.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- acc_clr  input  1  clear the accumulator; honoured independently of handshake.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_ones  output  1  out_y is all ones.
- out_par  output  1  XOR-reduction of out_y.

Behaviour:
- Opcodes:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 NAND: ~(a&b)
  - 3 NOR: ~(a|b)
  - 4 XOR: a^b
  - 5 XNOR: ~(a^b)
  - 6 NOT: ~a (b ignored)
  - 7 XACC: y = acc^a^b, and acc <= y.
- All results are exactly WIDTH bits. Flags are computed on the result, not the operands.
- Input acceptance: a beat is accepted when in_valid & in_ready.
- Latency: an accepted beat appears on out_* on the next cycle, provided the output register is empty or drains that same cycle.
- Output register: out_valid/out_y/flags hold stable while out_valid & ~out_ready (AXI-style; no retraction).
- Skid buffer: one entry. in_ready is registered and equals ~skid_valid.
  - If a beat is accepted while the output register is full and not draining, the beat goes to the skid buffer and in_ready drops next cycle.
  - When the output drains, the skid entry moves into the output register in that cycle and in_ready rises next cycle.
- Throughput: 1 beat/cycle with out_ready held high. After an out_ready gap, no beat is lost or duplicated, and order is preserved.
- Accumulator: WIDTH-bit register, updated only on acceptance of an XACC beat. The result is computed at acceptance time, so skid-buffered beats carry their already-computed values.
- Simultaneous acc_clr and XACC acceptance: the beat uses acc=0, and acc <= a^b.
- acc_clr alone sets acc <= 0 with no output beat.
- Reset (synchronous, rst=1 at a rising edge):
  - out_valid=0, out_y=0, out_zero=1, out_ones=0, out_par=0.
  - skid empty, in_ready=0 during the reset cycle and 1 on the first cycle after rst deasserts.
  - acc=0.
- Reset mid-operation discards the output register and skid contents with no partial beat. An in-flight handshake during the rst cycle is ignored.
- Undefined opcodes cannot occur; all 8 codes are defined.
- Boundary case WIDTH=1: flags degenerate correctly (zero=~y, ones=y, par=y).

Decomposition:
- Package logic_unit_pkg: opcode constants OP_AND..OP_XACC, OP_W, and the flag bit positions.
- Sub-module logic_unit_core: purely combinational; computes result and flags from (op, a, b, acc). The pipe module owns the handshake, skid buffer and accumulator.

Test Plan:
- Reset/idle: hold rst 2 cycles, then release. Expect out_valid=0 and out_zero=1 during reset, and in_ready=1 on the first cycle after release.
- Ops sweep, WIDTH=4, a=4'b1100, b=4'b1010, out_ready=1, ops 0..6 back-to-back. Expect one beat per cycle, 1-cycle latency, y = 1000, 1110, 0111, 0001, 0110, 1001, 0011.
  - Flags for op 1 (OR, 1110): zero=0, ones=0, par=1.
- Backpressure: stream 5 beats with out_ready=0 from cycle 2 to 5.
  - in_ready drops after 2 beats are held (output + skid).
  - Output stays stable while stalled.
  - After out_ready=1, all 5 results arrive in order with no duplicates.
- Accumulate: XACC a=4'h3,b=0, then a=4'h5,b=0, then a=4'hF,b=4'hF. Expect y=3, 6, 6.
  - Then assert acc_clr with XACC a=4'h1,b=0. Expect y=1.
- Reset mid-stream: assert rst while out_valid=1 and skid is full. Next cycle expect out_valid=0 and acc=0, and the held beats never appear.
- Flag corners: AND a=0 → y=0, zero=1. XNOR a=b → y=4'hF, ones=1, par=0. Repeat with WIDTH=1 and WIDTH=32.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode and flag definitions for the pipelined logic unit.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_XACC = 3'd7;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_ONES = 1;
  localparam int FLAG_PAR  = 2;
  localparam int FLAG_W    = 3;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational result and flag generation for one operand beat.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  acc,
  output logic [WIDTH-1:0]  y,
  output logic [FLAG_W-1:0] flags
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_XACC: y = acc ^ a ^ b;
    endcase
  end

  // Flags describe the result word, never the operands.
  always_comb begin
    flags            = '0;
    flags[FLAG_ZERO] = ~|y;
    flags[FLAG_ONES] = &y;
    flags[FLAG_PAR]  = ^y;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Handshaked logic unit: one output register, one-entry skid buffer, XOR accumulator.
module logic_unit_pipe #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par
);
  import logic_unit_pkg::*;

  logic              in_ready_r;
  logic              accept;
  logic              out_free;
  logic              skid_load;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_in;
  logic [WIDTH-1:0]  y_p0;
  logic [FLAG_W-1:0] flags_p0;
  logic              vld_p1;
  logic [WIDTH-1:0]  y_p1;
  logic [FLAG_W-1:0] flags_p1;
  logic              skid_vld;
  logic [WIDTH-1:0]  skid_y;
  logic [FLAG_W-1:0] skid_flags;

  assign accept    = in_valid & in_ready_r;
  assign out_free  = ~vld_p1 | out_ready;
  assign skid_load = accept & ~skid_vld & ~out_free;
  // A clear in the same cycle as an XACC beat makes that beat see an empty accumulator.
  assign acc_in    = acc_clr ? '0 : acc;

  // ---- stage p0: combinational evaluation of the incoming beat ----
  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (in_op),
    .a     (in_a),
    .b     (in_b),
    .acc   (acc_in),
    .y     (y_p0),
    .flags (flags_p0)
  );

  // ---- stage p1: output register, skid control, accumulator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1              <= 1'b0;
      y_p1                <= '0;
      flags_p1            <= '0;
      flags_p1[FLAG_ZERO] <= 1'b1;
      skid_vld            <= 1'b0;
      in_ready_r          <= 1'b0;
      acc                 <= '0;
    end else begin
      in_ready_r <= ~skid_vld | out_free;
      if (skid_vld) begin
        if (out_free) begin
          vld_p1   <= 1'b1;
          y_p1     <= skid_y;
          flags_p1 <= skid_flags;
          skid_vld <= 1'b0;
        end
      end else if (accept) begin
        if (out_free) begin
          vld_p1   <= 1'b1;
          y_p1     <= y_p0;
          flags_p1 <= flags_p0;
        end else begin
          skid_vld   <= 1'b1;
          in_ready_r <= 1'b0;
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (accept && (in_op == OP_XACC)) begin
        acc <= y_p0;
      end else if (acc_clr) begin
        acc <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_y     <= y_p0;
      skid_flags <= flags_p0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = vld_p1;
  assign out_y     = y_p1;
  assign out_zero  = flags_p1[FLAG_ZERO];
  assign out_ones  = flags_p1[FLAG_ONES];
  assign out_par   = flags_p1[FLAG_PAR];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: reference model with scoreboard plus literal checks.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_ready = 1'b1;
  logic [2:0] in_op = 3'd0;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  wire        in_ready, out_valid, out_zero, out_ones, out_par;
  wire  [3:0] out_y;

  logic        c_valid = 1'b0;
  logic [2:0]  c_op = 3'd0;
  logic [31:0] c_a = 32'd0;
  logic [31:0] c_b = 32'd0;
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;
  wire         r1, v1, z1, o1, p1;
  wire  [0:0]  y1;
  wire         r32, v32, z32, o32, p32;
  wire  [31:0] y32;

  logic_unit_pipe #(.WIDTH(4), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_ones(out_ones), .out_par(out_par)
  );

  logic_unit_pipe #(.WIDTH(1), .OP_W(3)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(r1),
    .in_op(c_op), .in_a(c_a[0:0]), .in_b(c_b[0:0]), .acc_clr(tie0),
    .out_valid(v1), .out_ready(tie1), .out_y(y1),
    .out_zero(z1), .out_ones(o1), .out_par(p1)
  );

  logic_unit_pipe #(.WIDTH(32), .OP_W(3)) dut_w32 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(r32),
    .in_op(c_op), .in_a(c_a), .in_b(c_b), .acc_clr(tie0),
    .out_valid(v32), .out_ready(tie1), .out_y(y32),
    .out_zero(z32), .out_ones(o32), .out_par(p32)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] q[$];
  logic [3:0] acc_m = 4'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_y(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] accv);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return accv ^ a ^ b;
    endcase
  endfunction

  // Scoreboard: every accepted beat is predicted, every delivered beat is popped in order.
  task automatic monitor();
    logic       held = 1'b0;
    logic [3:0] held_y = 4'd0;
    logic [3:0] e;
    logic [3:0] accv;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        acc_m = 4'd0;
        held  = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_y", 64'(out_y), 64'(held_y));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_beat", 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            chk("y", 64'(out_y), 64'(e));
            chk("zero", 64'(out_zero), 64'(e == 4'd0));
            chk("ones", 64'(out_ones), 64'(e == 4'hF));
            chk("par", 64'(out_par), 64'($countones(e) % 2));
          end
        end
        held   = out_valid & ~out_ready;
        held_y = out_y;
        if (in_valid && in_ready) begin
          accv = acc_clr ? 4'd0 : acc_m;
          e = ref_y(in_op, in_a, in_b, accv);
          q.push_back(e);
          if (in_op == 3'd7) acc_m = e;
          else if (acc_clr) acc_m = 4'd0;
        end else if (acc_clr) begin
          acc_m = 4'd0;
        end
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic clr);
    logic ok;
    int   n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; acc_clr = clr;
    n = 0;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic corner(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    c_valid = 1'b1; c_op = op; c_a = a; c_b = b;
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  logic [3:0] sweep_exp [7];

  initial begin
    sweep_exp = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011};
    fork
      monitor();
    join_none

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd1);
    chk("rst_out_ones", 64'(out_ones), 64'd0);
    chk("rst_out_par", 64'(out_par), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Accumulate
    send(3'd7, 4'h3, 4'h0, 1'b0); chk("xacc1", 64'(out_y), 64'h3);
    send(3'd7, 4'h5, 4'h0, 1'b0); chk("xacc2", 64'(out_y), 64'h6);
    send(3'd7, 4'hF, 4'hF, 1'b0); chk("xacc3", 64'(out_y), 64'h6);
    send(3'd7, 4'h1, 4'h0, 1'b1); chk("xacc_clr", 64'(out_y), 64'h1);

    // Ops sweep, back to back
    for (int k = 0; k < 7; k++) begin
      send(3'(k), 4'b1100, 4'b1010, 1'b0);
      chk("sweep_valid", 64'(out_valid), 64'd1);
      chk("sweep_y", 64'(out_y), 64'(sweep_exp[k]));
      if (k == 1) begin
        chk("or_zero", 64'(out_zero), 64'd0);
        chk("or_ones", 64'(out_ones), 64'd0);
        chk("or_par", 64'(out_par), 64'd1);
      end
    end
    @(posedge clk); #1;

    // Backpressure: output + skid fill, then release
    out_ready = 1'b0;
    send(3'd4, 4'h1, 4'h0, 1'b0);
    send(3'd4, 4'h2, 4'h0, 1'b0);
    chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
    fork
      begin
        send(3'd4, 4'h3, 4'h0, 1'b0);
        send(3'd4, 4'h4, 4'h0, 1'b0);
        send(3'd4, 4'h5, 4'h0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_y", 64'(out_y), 64'h1);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset mid-stream with output and skid full
    out_ready = 1'b0;
    send(3'd7, 4'h9, 4'h0, 1'b0);
    send(3'd4, 4'h2, 4'h0, 1'b0);
    chk("mid_skid_full", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_op = 3'd4; in_a = 4'h7; in_b = 4'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_post_in_ready", 64'(in_ready), 64'd1);
    chk("mid_post_valid", 64'(out_valid), 64'd0);
    send(3'd7, 4'h5, 4'h0, 1'b0);
    chk("mid_acc_cleared", 64'(out_y), 64'h5);

    // Flag corners, WIDTH=4
    send(3'd0, 4'h0, 4'h5, 1'b0);
    chk("and0_y", 64'(out_y), 64'h0);
    chk("and0_zero", 64'(out_zero), 64'd1);
    send(3'd5, 4'h6, 4'h6, 1'b0);
    chk("xnor_y", 64'(out_y), 64'hF);
    chk("xnor_ones", 64'(out_ones), 64'd1);
    chk("xnor_par", 64'(out_par), 64'd0);

    // Flag corners, WIDTH=1 and WIDTH=32
    corner(3'd0, 32'h0, 32'hFFFF_FFFF);
    chk("w1_and_valid", 64'(v1), 64'd1);
    chk("w1_and_y", 64'(y1), 64'd0);
    chk("w1_and_zero", 64'(z1), 64'd1);
    chk("w1_and_ones", 64'(o1), 64'd0);
    chk("w1_and_par", 64'(p1), 64'd0);
    chk("w32_and_y", 64'(y32), 64'd0);
    chk("w32_and_zero", 64'(z32), 64'd1);
    corner(3'd5, 32'h1234_5679, 32'h1234_5679);
    chk("w1_xnor_y", 64'(y1), 64'd1);
    chk("w1_xnor_zero", 64'(z1), 64'd0);
    chk("w1_xnor_ones", 64'(o1), 64'd1);
    chk("w1_xnor_par", 64'(p1), 64'd1);
    chk("w32_xnor_y", 64'(y32), 64'hFFFF_FFFF);
    chk("w32_xnor_ones", 64'(o32), 64'd1);
    chk("w32_xnor_par", 64'(p32), 64'd0);
    chk("w32_xnor_zero", 64'(z32), 64'd0);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      acc_clr   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; acc_clr = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_drained", 64'(q.size()), 64'd0);
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
